// File: rtl/exu_mul_pkg.sv
// rtl/exu_mul_pkg.sv - shared types, latency and operand/result helpers for the multiplier issue path
package exu_mul_pkg;

  // Multiply micro-op encoding as delivered by dispatch
  typedef enum logic [1:0] {
    MUL_W   = 2'd0,
    MULH_W  = 2'd1,
    MULH_WU = 2'd2,
    MUL_D   = 2'd3
  } mul_op_e;

  // Pipeline depth of exu_mul_ctl: operands captured at issue, result visible three cycles later
  localparam int MUL_LATENCY = 3;

  // Widest ROB tag the tag pipe can carry; narrower tags occupy the low bits
  localparam int MAX_TAG_W = 16;

  // One tag-pipe stage: tracks an op in flight alongside the multiplier
  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
    mul_op_e              op;
  } mul_pipe_entry_t;

  // Operand conditioning: word ops see only the low 32 bits, extended by the op's signedness
  function automatic logic [63:0] mul_cond_src(input mul_op_e op, input logic [63:0] src);
    logic [63:0] r;
    case (op)
      MUL_W, MULH_W: r = {{32{src[31]}}, src[31:0]};
      MULH_WU:       r = {32'h0, src[31:0]};
      default:       r = src;
    endcase
    return r;
  endfunction

  // Result selection: word results are always sign-extended to 64 bits
  function automatic logic [63:0] mul_post(input mul_op_e op, input logic [63:0] res);
    logic [63:0] r;
    case (op)
      MUL_W:           r = {{32{res[31]}}, res[31:0]};
      MULH_W, MULH_WU: r = {{32{res[63]}}, res[63:32]};
      default:         r = res;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exu_mul_wb_fifo.sv
// rtl/exu_mul_wb_fifo.sv - synchronous writeback FIFO with occupancy count and synchronous clear
module exu_mul_wb_fifo
  import exu_mul_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  assign do_pop   = pop && (count_q != '0);
  assign valid    = (count_q != '0);
  assign count    = count_q;
  // Head is forced to zero when empty so the output is quiet in reset and idle
  assign pop_data = valid ? mem_q[rd_ptr_q] : '0;

  // Pointers and occupancy; clear wins over any same-cycle push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents only matter behind a valid count, so no reset
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  // The issue credit guarantees a free slot for every push
  assert property (@(posedge clk) disable iff (!rst_n)
                   (push && !clear) |-> ((count_q != DEPTH_C) || do_pop));

endmodule

// File: rtl/exu_mul_issue_ctl.sv
// rtl/exu_mul_issue_ctl.sv - issue, tag tracking and credited writeback for the 3-stage multiplier
module exu_mul_issue_ctl
  import exu_mul_pkg::*;
#(
  parameter int TAG_W    = 6,
  parameter int WB_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [63:0]      req_src1,
  input  logic [63:0]      req_src2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             mul_signed,
  output logic             mul_low,
  output logic [63:0]      mul_src1,
  output logic [63:0]      mul_src2,
  input  logic [63:0]      mul_result,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [63:0]      wb_data,
  output logic [TAG_W-1:0] wb_tag,
  output logic             busy
);

  localparam int             CNT_W   = $clog2(WB_DEPTH + 1);
  localparam int             FIFO_W  = TAG_W + 64;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(WB_DEPTH);

  mul_op_e          op_d;
  logic             accept;
  mul_pipe_entry_t  stage0_d;
  mul_pipe_entry_t  pipe_q [MUL_LATENCY];
  mul_pipe_entry_t  last_entry;
  logic             any_inflight;
  logic [CNT_W:0]   occ;
  logic             fifo_valid;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_push;
  logic             fifo_pop;
  logic [FIFO_W-1:0] fifo_push_data;
  logic [FIFO_W-1:0] fifo_pop_data;
  logic             unused_tag_bits;

  // Credit: every op in flight or buffered owns a FIFO slot; a same-cycle pop frees one early
  assign req_ready = rst_n && !flush && ((occ < DEPTH_V) || (fifo_valid && wb_ready));
  assign accept    = req_valid && req_ready;

  // Decode the accepted op into multiplier controls; everything idles at zero otherwise
  always_comb begin
    op_d       = mul_op_e'(req_op);
    mul_low    = accept;
    mul_signed = accept && ((op_d == MUL_W) || (op_d == MULH_W));
    mul_src1   = accept ? mul_cond_src(op_d, req_src1) : '0;
    mul_src2   = accept ? mul_cond_src(op_d, req_src2) : '0;
    stage0_d   = '0;
    if (accept) begin
      stage0_d.valid            = 1'b1;
      stage0_d.tag[TAG_W-1:0]   = req_tag;
      stage0_d.op               = op_d;
    end
  end

  // Tag pipe shadows the multiplier stage for stage; flush drops every tracked op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_LATENCY; i++) pipe_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < MUL_LATENCY; i++) pipe_q[i].valid <= 1'b0;
    end else begin
      pipe_q[0] <= stage0_d;
      for (int i = 1; i < MUL_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Occupancy and activity summed over the pipe and the writeback buffer
  always_comb begin
    occ          = {1'b0, fifo_count};
    any_inflight = 1'b0;
    for (int i = 0; i < MUL_LATENCY; i++) begin
      occ          = occ + (CNT_W + 1)'(pipe_q[i].valid);
      any_inflight = any_inflight | pipe_q[i].valid;
    end
  end

  // Result of the op leaving the last stage is shaped and buffered in the same cycle
  assign last_entry      = pipe_q[MUL_LATENCY-1];
  assign fifo_push       = last_entry.valid && !flush;
  assign fifo_push_data  = {last_entry.tag[TAG_W-1:0], mul_post(last_entry.op, mul_result)};
  assign fifo_pop        = fifo_valid && wb_ready;
  assign unused_tag_bits = ^last_entry.tag;

  exu_mul_wb_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (WB_DEPTH)
  ) u_wb_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign wb_valid          = fifo_valid;
  assign {wb_tag, wb_data} = fifo_pop_data;
  assign busy              = any_inflight || fifo_valid;

endmodule
